cgra_ctx_control_unit: RTL and testbench
========================================

Name: cgra_ctx_control_unit

Overview:
Next-generation CGRA main control FSM. Tracks configuration validity for NUM_CTX independent contexts and launches execution of a selected context. Adds an execution-cycle counter, a programmable watchdog timeout, software abort, completion status and a sticky, acknowledged interrupt. Sits between the register interface and configuration loader on one side and the memory-node and CGRA array on the other.

Parameters:
NUM_CTX, 4, number of configuration contexts (>=2)
CTX_W, $clog2(NUM_CTX), context index width (derived, not overridden)
CYC_W, 32, width of cycle counter and timeout value

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  start pulse; sampled only in IDLE
start_ctx_i  in  CTX_W  context to execute, sampled with start_i
conf_ctx_i  in  CTX_W  context targeted by conf_change_i/conf_done_i
conf_change_i  in  1  invalidate context conf_ctx_i
conf_done_i  in  1  context conf_ctx_i fully loaded
mn_done_i  in  1  memory nodes finished
abort_i  in  1  software abort
timeout_i  in  CYC_W  max EXEC cycles; 0 = watchdog disabled
intr_ack_i  in  1  clears pending interrupt
exec_o  out  1  high in EXEC
busy_o  out  1  state != IDLE
clr_mn_o  out  1  memory-node clear pulse
clr_cgra_o  out  1  CGRA clear pulse
conf_needed_o  out  NUM_CTX  bit i = context i not valid
active_ctx_o  out  CTX_W  latched context
status_o  out  2  0 OK, 1 ABORT, 2 TIMEOUT, 3 BADCTX
cycles_o  out  CYC_W  EXEC cycles of last/current run
intr_o  out  1  interrupt, level, held until ack
state_o  out  2  0 IDLE, 1 WAIT, 2 EXEC, 3 DONE

Behaviour:
- Reset: state IDLE, all conf_valid bits 0 (conf_needed_o all 1s), active_ctx/status/cycles 0, intr pending 0. All other outputs 0. Reset mid-run returns immediately to this state.
- conf_valid[i] register updates every cycle in any state:
  - conf_change_i clears conf_valid[conf_ctx_i].
  - conf_done_i sets it.
  - Both in the same cycle: clear wins.
  - Out-of-range conf_ctx_i (>= NUM_CTX) is ignored.
  - Flag changes never move the FSM.
- IDLE, start_i=1:
  - Latch start_ctx_i into active_ctx. Clear cycles and status.
  - If start_ctx_i >= NUM_CTX: go to DONE, status BADCTX.
  - Else if registered conf_valid[start_ctx_i]=1: go to EXEC.
  - Else: go to WAIT.
  - start_i outside IDLE is ignored.
- WAIT:
  - Go to EXEC when registered conf_valid[active_ctx]=1. This is one cycle after the conf_done_i that sets it.
  - abort_i: go to DONE, status ABORT.
- EXEC:
  - cycles increments every EXEC cycle and saturates at all-ones.
  - Exit priority, highest first:
    - mn_done_i: DONE, status OK.
    - abort_i: DONE, status ABORT.
    - timeout_i != 0 and cycles == timeout_i-1: DONE, status TIMEOUT. EXEC therefore lasts exactly timeout_i cycles.
  - cycles counts the exiting cycle, so a run with mn_done_i in the first EXEC cycle gives cycles_o=1.
- DONE: lasts exactly 1 cycle, then IDLE. clr_mn_o=1 during DONE. status_o and cycles_o hold until the next accepted start.
- clr_cgra_o = (state==DONE) OR (conf_done_i AND NOT conf_change_i AND in-range conf_ctx_i AND NOT conf_valid[conf_ctx_i]). This gives one pulse on the first completion of a context load.
- Interrupt:
  - intr_o = (state==DONE) OR intr_pend.
  - intr_pend is set on the DONE cycle and cleared by intr_ack_i.
  - Set and ack in the same cycle: set wins.
  - A new start is allowed while the interrupt is pending.
- exec_o = (state==EXEC). busy_o = (state!=IDLE). state_o mirrors state.

Test Plan:
- After reset, conf_done_i ctx2 → conf_needed_o=4'b1011, clr_cgra_o pulses once. A second conf_done_i ctx2 → no clr_cgra_o pulse.
- start ctx2 with ctx2 valid → EXEC next cycle. mn_done_i after 10 EXEC cycles → DONE 1 cycle with clr_mn_o=1, status_o=0, cycles_o=10. intr_o stays high until intr_ack_i.
- start ctx1 with ctx1 invalid → WAIT. conf_done_i ctx1 at cycle t → EXEC at t+2. conf_done_i ctx3 in WAIT → no transition.
- timeout_i=5, mn_done_i never asserted → exec_o high exactly 5 cycles, status_o=2, cycles_o=5. timeout_i=0 → EXEC holds 1000 cycles.
- abort_i in WAIT → DONE, status_o=1. abort_i and mn_done_i together in EXEC → status_o=0. conf_change_i and conf_done_i on the same ctx → flag stays 0.
- NUM_CTX=3, start_ctx_i=3 → DONE directly with status_o=3. Reset asserted during EXEC → state_o=0, intr_o=0, conf_needed_o=3'b111.

Source files
------------

// File: rtl/cgra_ctx_control_unit.sv
// CGRA context control: per-context config validity, launch FSM,
// EXEC cycle counter, watchdog, abort, status and sticky interrupt.
//
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   start_i, start_ctx_i    launch request and context (IDLE only)
//   conf_ctx_i              context for conf_change_i / conf_done_i
//   conf_change_i           invalidate conf_ctx_i
//   conf_done_i             conf_ctx_i fully loaded
//   mn_done_i, abort_i      memory nodes done / software abort
//   timeout_i               EXEC cycle limit, 0 disables watchdog
//   intr_ack_i              clears pending interrupt
//   exec_o, busy_o          state==EXEC / state!=IDLE
//   clr_mn_o, clr_cgra_o    memory-node and array clear pulses
//   conf_needed_o           bit i set while context i is not valid
//   active_ctx_o            context of the last accepted start
//   status_o                0 OK, 1 ABORT, 2 TIMEOUT, 3 BADCTX
//   cycles_o                EXEC cycles of the last/current run
//   intr_o                  level interrupt, held until ack
//   state_o                 0 IDLE, 1 WAIT, 2 EXEC, 3 DONE
module cgra_ctx_control_unit #(
  parameter int unsigned NUM_CTX = 4,
  parameter int unsigned CTX_W   = $clog2(NUM_CTX),
  parameter int unsigned CYC_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [CTX_W-1:0]   start_ctx_i,
  input  logic [CTX_W-1:0]   conf_ctx_i,
  input  logic               conf_change_i,
  input  logic               conf_done_i,
  input  logic               mn_done_i,
  input  logic               abort_i,
  input  logic [CYC_W-1:0]   timeout_i,
  input  logic               intr_ack_i,
  output logic               exec_o,
  output logic               busy_o,
  output logic               clr_mn_o,
  output logic               clr_cgra_o,
  output logic [NUM_CTX-1:0] conf_needed_o,
  output logic [CTX_W-1:0]   active_ctx_o,
  output logic [1:0]         status_o,
  output logic [CYC_W-1:0]   cycles_o,
  output logic               intr_o,
  output logic [1:0]         state_o
);

  localparam int unsigned PAD = 1 << CTX_W;
  localparam logic [CTX_W:0] NCTX = (CTX_W+1)'(NUM_CTX);

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_ABORT = 2'd1;
  localparam logic [1:0] ST_TMO   = 2'd2;
  localparam logic [1:0] ST_BAD   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q;
  logic [NUM_CTX-1:0] valid_q;
  logic [PAD-1:0]     valid_pad;
  logic [CTX_W-1:0]   act_q;
  logic [1:0]         status_q;
  logic [CYC_W-1:0]   cycles_q;
  logic [CYC_W-1:0]   cyc_inc;
  logic               pend_q;
  logic               start_ok;
  logic               conf_ok;
  logic               tmo_hit;

  // Padding to a power of two keeps every index in bounds;
  // the pad bits read as "not valid".
  assign valid_pad = PAD'(valid_q);

  assign start_ok = {1'b0, start_ctx_i} < NCTX;
  assign conf_ok  = {1'b0, conf_ctx_i} < NCTX;

  assign cyc_inc = (&cycles_q) ? cycles_q
                               : cycles_q + 1'b1;

  assign tmo_hit = (timeout_i != '0) &&
                   (cycles_q == timeout_i - 1'b1);

  // Out-of-range indices never match any i, so they are ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (conf_ctx_i == CTX_W'(i)) begin
          if (conf_change_i)
            valid_q[i] <= 1'b0;
          else if (conf_done_i)
            valid_q[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      act_q    <= '0;
      status_q <= ST_OK;
      cycles_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      if (state_q == S_DONE)
        pend_q <= 1'b1;
      else if (intr_ack_i)
        pend_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            act_q    <= start_ctx_i;
            cycles_q <= '0;
            status_q <= ST_OK;
            if (!start_ok) begin
              state_q  <= S_DONE;
              status_q <= ST_BAD;
            end else if (valid_pad[start_ctx_i]) begin
              state_q <= S_EXEC;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (abort_i) begin
            state_q  <= S_DONE;
            status_q <= ST_ABORT;
          end else if (valid_pad[act_q]) begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          cycles_q <= cyc_inc;
          if (mn_done_i) begin
            state_q  <= S_DONE;
            status_q <= ST_OK;
          end else if (abort_i) begin
            state_q  <= S_DONE;
            status_q <= ST_ABORT;
          end else if (tmo_hit) begin
            state_q  <= S_DONE;
            status_q <= ST_TMO;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign exec_o        = (state_q == S_EXEC);
  assign busy_o        = (state_q != S_IDLE);
  assign clr_mn_o      = (state_q == S_DONE);
  assign conf_needed_o = ~valid_q;
  assign active_ctx_o  = act_q;
  assign status_o      = status_q;
  assign cycles_o      = cycles_q;
  assign intr_o        = (state_q == S_DONE) | pend_q;
  assign state_o       = state_q;

  // Array clear on the first completed load of a context.
  assign clr_cgra_o = (state_q == S_DONE) |
                      (conf_done_i & ~conf_change_i &
                       conf_ok & ~valid_pad[conf_ctx_i]);

endmodule

// File: tb/tb_cgra_ctx_control_unit.sv
// Directed bench for cgra_ctx_control_unit: vector table
// plus hand sequences for watchdog, reset and NUM_CTX=3.
module tb_cgra_ctx_control_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  start_ctx_i = '0;
  logic [1:0]  conf_ctx_i = '0;
  logic        conf_change_i = 1'b0;
  logic        conf_done_i = 1'b0;
  logic        mn_done_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] timeout_i = '0;
  logic        intr_ack_i = 1'b0;
  logic        exec_o, busy_o, clr_mn_o, clr_cgra_o;
  logic [3:0]  conf_needed_o;
  logic [1:0]  active_ctx_o, status_o, state_o;
  logic [31:0] cycles_o;
  logic        intr_o;

  logic        s3_start = 1'b0;
  logic [1:0]  s3_sctx = '0;
  logic [1:0]  s3_cctx = '0;
  logic        s3_done = 1'b0;
  logic        e3, b3, cm3, cc3, i3;
  logic [2:0]  need3;
  logic [1:0]  act3, st3, state3;
  logic [31:0] cyc3;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  cgra_ctx_control_unit #(.NUM_CTX(4)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .start_i(start_i), .start_ctx_i(start_ctx_i),
    .conf_ctx_i(conf_ctx_i),
    .conf_change_i(conf_change_i),
    .conf_done_i(conf_done_i),
    .mn_done_i(mn_done_i), .abort_i(abort_i),
    .timeout_i(timeout_i), .intr_ack_i(intr_ack_i),
    .exec_o(exec_o), .busy_o(busy_o),
    .clr_mn_o(clr_mn_o), .clr_cgra_o(clr_cgra_o),
    .conf_needed_o(conf_needed_o),
    .active_ctx_o(active_ctx_o),
    .status_o(status_o), .cycles_o(cycles_o),
    .intr_o(intr_o), .state_o(state_o)
  );

  cgra_ctx_control_unit #(.NUM_CTX(3)) u_dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .start_i(s3_start), .start_ctx_i(s3_sctx),
    .conf_ctx_i(s3_cctx),
    .conf_change_i(1'b0),
    .conf_done_i(s3_done),
    .mn_done_i(1'b0), .abort_i(1'b0),
    .timeout_i(32'd0), .intr_ack_i(1'b0),
    .exec_o(e3), .busy_o(b3),
    .clr_mn_o(cm3), .clr_cgra_o(cc3),
    .conf_needed_o(need3),
    .active_ctx_o(act3),
    .status_o(st3), .cycles_o(cyc3),
    .intr_o(i3), .state_o(state3)
  );

  typedef struct {
    logic       st;
    logic [1:0] sctx;
    logic [1:0] cctx;
    logic       chg, dn, mn, ab, ack;
    logic       e_clr;
    logic [1:0] e_state;
    logic [3:0] e_need;
    logic [1:0] e_act;
    logic [1:0] e_status;
    int         e_cyc;
    logic       e_intr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic st, input logic [1:0] sctx,
    input logic [1:0] cctx, input logic chg,
    input logic dn, input logic mn, input logic ab,
    input logic ack, input logic clr,
    input logic [1:0] state, input logic [3:0] need,
    input logic [1:0] act, input logic [1:0] status,
    input int cyc, input logic intr);
    vec_t v;
    v.st = st; v.sctx = sctx; v.cctx = cctx;
    v.chg = chg; v.dn = dn; v.mn = mn;
    v.ab = ab; v.ack = ack; v.e_clr = clr;
    v.e_state = state; v.e_need = need;
    v.e_act = act; v.e_status = status;
    v.e_cyc = cyc; v.e_intr = intr;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    int n;

    // state: 0 IDLE 1 WAIT 2 EXEC 3 DONE
    vq.push_back(mk(0,0,2,0,1,0,0,0, 1,0,4'b1011,0,0,0,0));
    vq.push_back(mk(0,0,2,0,1,0,0,0, 0,0,4'b1011,0,0,0,0));
    vq.push_back(mk(1,2,0,0,0,0,0,0, 0,2,4'b1011,2,0,0,0));
    for (int k = 1; k <= 9; k++)
      vq.push_back(mk(0,0,0,0,0,0,0,0,
                      0,2,4'b1011,2,0,k,0));
    vq.push_back(mk(0,0,0,0,0,1,0,0, 0,3,4'b1011,2,0,10,1));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 1,0,4'b1011,2,0,10,1));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 0,0,4'b1011,2,0,10,1));
    vq.push_back(mk(0,0,0,0,0,0,0,1, 0,0,4'b1011,2,0,10,0));
    vq.push_back(mk(1,1,0,0,0,0,0,0, 0,1,4'b1011,1,0,0,0));
    vq.push_back(mk(0,0,3,0,1,0,0,0, 1,1,4'b0011,1,0,0,0));
    vq.push_back(mk(0,0,1,0,1,0,0,0, 1,1,4'b0001,1,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 0,2,4'b0001,1,0,0,0));
    vq.push_back(mk(0,0,0,0,0,1,1,0, 0,3,4'b0001,1,0,1,1));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 1,0,4'b0001,1,0,1,1));
    vq.push_back(mk(0,0,0,0,0,0,0,1, 0,0,4'b0001,1,0,1,0));
    vq.push_back(mk(0,0,2,1,1,0,0,0, 0,0,4'b0101,1,0,1,0));
    vq.push_back(mk(1,2,0,0,0,0,0,0, 0,1,4'b0101,2,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,1,0, 0,3,4'b0101,2,1,0,1));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 1,0,4'b0101,2,1,0,1));
    vq.push_back(mk(1,0,0,0,0,0,0,1, 0,1,4'b0101,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,1,0, 0,3,4'b0101,0,1,0,1));
    vq.push_back(mk(0,0,0,0,0,0,0,1, 1,0,4'b0101,0,1,0,1));
    vq.push_back(mk(0,0,0,0,0,0,0,1, 0,0,4'b0101,0,1,0,0));
    vq.push_back(mk(1,3,0,0,0,0,0,0, 0,2,4'b0101,3,0,0,0));
    vq.push_back(mk(1,0,0,0,0,0,0,0, 0,2,4'b0101,3,0,1,0));
    vq.push_back(mk(0,0,0,0,0,0,1,0, 0,3,4'b0101,3,1,2,1));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 1,0,4'b0101,3,1,2,1));
    vq.push_back(mk(0,0,0,0,0,0,0,1, 0,0,4'b0101,3,1,2,0));

    // reset state
    #2;
    chk("rst state", state_o, 0);
    chk("rst need", conf_needed_o, 4'b1111);
    chk("rst status", status_o, 0);
    chk("rst cycles", cycles_o, 0);
    chk("rst act", active_ctx_o, 0);
    chk("rst intr", intr_o, 0);
    chk("rst outs",
        {exec_o, busy_o, clr_mn_o, clr_cgra_o}, 0);
    chk("rst need3", need3, 3'b111);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // NUM_CTX=3: out-of-range config and start
    @(negedge clk_i);
    s3_cctx = 2'd3;
    s3_done = 1'b1;
    #1;
    chk("n3 clr oor", cc3, 0);
    @(posedge clk_i); #1;
    chk("n3 need oor", need3, 3'b111);
    @(negedge clk_i);
    s3_done = 1'b0;
    s3_start = 1'b1;
    s3_sctx = 2'd3;
    @(posedge clk_i); #1;
    chk("n3 bad state", state3, 3);
    chk("n3 bad status", st3, 3);
    chk("n3 bad act", act3, 3);
    chk("n3 bad clrmn", cm3, 1);
    @(negedge clk_i);
    s3_start = 1'b0;
    @(posedge clk_i); #1;
    chk("n3 back idle", state3, 0);
    chk("n3 intr pend", i3, 1);

    foreach (vq[i]) begin
      @(negedge clk_i);
      start_i = vq[i].st;
      start_ctx_i = vq[i].sctx;
      conf_ctx_i = vq[i].cctx;
      conf_change_i = vq[i].chg;
      conf_done_i = vq[i].dn;
      mn_done_i = vq[i].mn;
      abort_i = vq[i].ab;
      intr_ack_i = vq[i].ack;
      #1;
      chk($sformatf("v%0d clr_cgra", i),
          clr_cgra_o, vq[i].e_clr);
      @(posedge clk_i); #1;
      chk($sformatf("v%0d state", i),
          state_o, vq[i].e_state);
      chk($sformatf("v%0d need", i),
          conf_needed_o, vq[i].e_need);
      chk($sformatf("v%0d act", i),
          active_ctx_o, vq[i].e_act);
      chk($sformatf("v%0d status", i),
          status_o, vq[i].e_status);
      chk($sformatf("v%0d cycles", i),
          cycles_o, vq[i].e_cyc);
      chk($sformatf("v%0d intr", i),
          intr_o, vq[i].e_intr);
      chk($sformatf("v%0d flags", i),
          {exec_o, busy_o, clr_mn_o},
          {vq[i].e_state == 2, vq[i].e_state != 0,
           vq[i].e_state == 3});
    end

    // watchdog: 5 EXEC cycles
    @(negedge clk_i);
    start_i = 1'b0; conf_done_i = 1'b0;
    mn_done_i = 1'b0; abort_i = 1'b0;
    intr_ack_i = 1'b0;
    timeout_i = 32'd5;
    start_i = 1'b1;
    start_ctx_i = 2'd3;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n = 0;
    for (int c = 0; c < 50 && state_o != 2'd3; c++) begin
      if (exec_o) n++;
      @(posedge clk_i); #1;
    end
    chk("tmo done", state_o, 3);
    chk("tmo exec len", n, 5);
    chk("tmo status", status_o, 2);
    chk("tmo cycles", cycles_o, 5);
    @(posedge clk_i); #1;
    chk("tmo idle", state_o, 0);

    // watchdog disabled: run 1000 cycles, intr still pending
    timeout_i = 32'd0;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n = 0;
    for (int c = 0; c < 1000; c++) begin
      if (exec_o) n++;
      @(posedge clk_i); #1;
    end
    chk("nowd exec len", n, 1000);
    chk("nowd cycles", cycles_o, 1000);
    chk("nowd intr pend", intr_o, 1);

    // async reset mid-EXEC
    rst_ni = 1'b0;
    #1;
    chk("mid rst state", state_o, 0);
    chk("mid rst intr", intr_o, 0);
    chk("mid rst need", conf_needed_o, 4'b1111);
    chk("mid rst cycles", cycles_o, 0);
    chk("mid rst need3", need3, 3'b111);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("post rst idle", state_o, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
